// File: rtl/sample_delay_line_ctrl_if.sv
// Bundles the sample input, single-port RAM and tap output signals of the delay-line controller.
// master = the controller side, slave = the surrounding sample source, RAM and MAC.
interface sample_delay_line_ctrl_if #(
   parameter int AddrWidth = 9,
   parameter int DataWidth = 16
);
   logic [DataWidth-1:0] sample_data;
   logic                 sample_valid;
   logic                 sample_ready;
   logic                 ram_wr;
   logic [AddrWidth-1:0] ram_addr;
   logic [DataWidth-1:0] ram_wdata;
   logic [DataWidth-1:0] ram_rdata;
   logic [DataWidth-1:0] tap_data;
   logic [AddrWidth-1:0] tap_index;
   logic                 tap_valid;
   logic                 tap_last;
   logic                 tap_ready;

   modport master (
      input  sample_data, sample_valid, ram_rdata, tap_ready,
      output sample_ready, ram_wr, ram_addr, ram_wdata,
             tap_data, tap_index, tap_valid, tap_last
   );

   modport slave (
      output sample_data, sample_valid, ram_rdata, tap_ready,
      input  sample_ready, ram_wr, ram_addr, ram_wdata,
             tap_data, tap_index, tap_valid, tap_last
   );
endinterface

// File: rtl/sample_delay_line_ctrl.sv
// Circular-buffer delay line: writes each new sample, then streams NumTaps taps newest-to-oldest.
// Optional power-up RAM clear sweep selected by macro DELAY_LINE_CLEAR_EN.
//
// state   | meaning
// IDLE    | sample_ready high, waiting for a sample
// WRITE   | one-cycle RAM write of the latched sample at wr_ptr
// READ    | read taps k = 0..NumTaps-1 at wr_ptr-k, drain output register
// CLEAR   | (DELAY_LINE_CLEAR_EN only) write zero to every RAM address
module sample_delay_line_ctrl #(
   parameter int AddrWidth = 9,
   parameter int DataWidth = 16,
   parameter int NumTaps   = 32
) (
   input logic clk_i,
   input logic rst_n_i,
   sample_delay_line_ctrl_if.master dl_if
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ
`ifdef DELAY_LINE_CLEAR_EN
      , S_CLEAR
`endif
   } state_e;

   localparam logic [AddrWidth-1:0] LastTap = AddrWidth'(NumTaps - 1);
   localparam logic [AddrWidth-1:0] AddrMax = '1;
   localparam logic [AddrWidth-1:0] AddrOne = AddrWidth'(1);

   state_e               state_q;
   logic [AddrWidth-1:0] wr_ptr_q, k_q, ram_addr_q, tap_index_q;
   logic [DataWidth-1:0] ram_wdata_q, tap_data_q;
   logic                 ram_wr_q, sample_ready_q, tap_valid_q, tap_last_q, issued_q;
   logic [AddrWidth-1:0] rd_addr_d;
   logic                 tap_xfer, cap_en;

   always_comb begin
      tap_xfer  = tap_valid_q & dl_if.tap_ready;
      cap_en    = ~tap_valid_q | dl_if.tap_ready;
      rd_addr_d = wr_ptr_q - k_q - AddrOne;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
`ifdef DELAY_LINE_CLEAR_EN
         state_q <= S_CLEAR;
`else
         state_q <= S_IDLE;
`endif
         wr_ptr_q       <= '0;
         k_q            <= '0;
         ram_addr_q     <= '0;
         ram_wdata_q    <= '0;
         ram_wr_q       <= 1'b0;
         sample_ready_q <= 1'b0;
         tap_data_q     <= '0;
         tap_index_q    <= '0;
         tap_valid_q    <= 1'b0;
         tap_last_q     <= 1'b0;
         issued_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (sample_ready_q && dl_if.sample_valid) begin
                  sample_ready_q <= 1'b0;
                  ram_wr_q       <= 1'b1;
                  ram_addr_q     <= wr_ptr_q;
                  ram_wdata_q    <= dl_if.sample_data;
                  state_q        <= S_WRITE;
               end else begin
                  sample_ready_q <= 1'b1;
               end
            end
            S_WRITE: begin
               ram_wr_q   <= 1'b0;
               ram_addr_q <= wr_ptr_q;
               k_q        <= '0;
               issued_q   <= 1'b0;
               state_q    <= S_READ;
            end
            S_READ: begin
               // issued_q: all taps captured, only waiting for the last one to leave
               if (!issued_q && cap_en) begin
                  tap_data_q  <= dl_if.ram_rdata;
                  tap_index_q <= k_q;
                  tap_valid_q <= 1'b1;
                  tap_last_q  <= (k_q == LastTap);
                  if (k_q == LastTap) begin
                     issued_q <= 1'b1;
                  end else begin
                     k_q        <= k_q + AddrOne;
                     ram_addr_q <= rd_addr_d;
                  end
               end else if (tap_xfer) begin
                  tap_valid_q <= 1'b0;
                  tap_last_q  <= 1'b0;
                  if (tap_last_q) begin
                     wr_ptr_q       <= wr_ptr_q + AddrOne;
                     k_q            <= '0;
                     sample_ready_q <= 1'b1;
                     state_q        <= S_IDLE;
                  end
               end
            end
`ifdef DELAY_LINE_CLEAR_EN
            S_CLEAR: begin
               // first cycle after reset has ram_wr low; it arms the sweep at address 0
               if (!ram_wr_q) begin
                  ram_wr_q    <= 1'b1;
                  ram_addr_q  <= '0;
                  ram_wdata_q <= '0;
               end else if (ram_addr_q == AddrMax) begin
                  ram_wr_q       <= 1'b0;
                  ram_addr_q     <= '0;
                  sample_ready_q <= 1'b1;
                  state_q        <= S_IDLE;
               end else begin
                  ram_addr_q <= ram_addr_q + AddrOne;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dl_if.sample_ready = sample_ready_q;
   assign dl_if.ram_wr       = ram_wr_q;
   assign dl_if.ram_addr     = ram_addr_q;
   assign dl_if.ram_wdata    = ram_wdata_q;
   assign dl_if.tap_data     = tap_data_q;
   assign dl_if.tap_index    = tap_index_q;
   assign dl_if.tap_valid    = tap_valid_q;
   assign dl_if.tap_last     = tap_last_q;
endmodule

// File: tb/tb_sample_delay_line_ctrl.sv
// Bench for sample_delay_line_ctrl: RAM model plus a sample-history reference model.
// Build with or without DELAY_LINE_CLEAR_EN; expectations follow the macro.
module tb_sample_delay_line_ctrl;
   localparam int AW    = 9;
   localparam int DW    = 16;
   localparam int NT    = 16;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sample_delay_line_ctrl_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

   sample_delay_line_ctrl #(.AddrWidth(AW), .DataWidth(DW), .NumTaps(NT)) dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .dl_if  (bus)
   );

   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) if (bus.ram_wr) ram[bus.ram_addr] <= bus.ram_wdata;
   assign bus.ram_rdata = ram[bus.ram_addr];

   logic [DW-1:0] hist[$];
   int errors;
   int checks;

   // Expected value of tap j for the newest sample; 0 = value unspecified.
   function automatic bit model_tap(input int j, output logic [DW-1:0] v);
      int n;
      n = hist.size() - 1 - j;
      v = '0;
      if (n >= 0) begin
         v = hist[n];
         return 1'b1;
      end
`ifdef DELAY_LINE_CLEAR_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_post_reset();
      int nwr;
      bit done;
      nwr  = 0;
      done = 1'b0;
      for (int i = 0; i < DEPTH + 20 && !done; i++) begin
         if (bus.sample_ready) begin
            done = 1'b1;
         end else begin
            if (bus.ram_wr) begin
               checks++;
               if (bus.ram_wdata !== '0 || bus.ram_addr !== AW'(nwr)) begin
                  errors++;
                  $display("FAIL clear_write: addr=%0d data=%h want addr=%0d data=0",
                           bus.ram_addr, bus.ram_wdata, nwr);
               end
               nwr++;
            end
            @(negedge clk);
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL ready_after_reset: sample_ready never rose");
      end
      checks++;
`ifdef DELAY_LINE_CLEAR_EN
      if (nwr != DEPTH) begin
         errors++;
         $display("FAIL clear_len: %0d writes want %0d", nwr, DEPTH);
      end
`else
      if (nwr != 0) begin
         errors++;
         $display("FAIL no_write_after_reset: %0d writes want 0", nwr);
      end
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (bus.ram_wr !== 1'b0 || bus.sample_ready !== 1'b0 || bus.tap_valid !== 1'b0 ||
          bus.tap_last !== 1'b0 || bus.tap_data !== '0 || bus.tap_index !== '0 ||
          bus.ram_addr !== '0 || bus.ram_wdata !== '0) begin
         errors++;
         $display("FAIL %s: wr=%b rdy=%b tv=%b tl=%b td=%h ti=%0d ra=%0d wd=%h want all 0",
                  tag, bus.ram_wr, bus.sample_ready, bus.tap_valid, bus.tap_last,
                  bus.tap_data, bus.tap_index, bus.ram_addr, bus.ram_wdata);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_state");
      rst_n = 1'b1;
      hist.delete();
      check_post_reset();
   endtask

   // Offers one sample; returns at the negedge of cycle N+2 (N = accept edge).
   task automatic accept(input logic [DW-1:0] data, input bit keep_valid);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 700 && !ok; i++) begin
         if (bus.sample_ready) ok = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_ready: sample_ready=0 want 1");
         return;
      end
      bus.sample_data  = data;
      bus.sample_valid = 1'b1;
      @(posedge clk);
      hist.push_back(data);
      @(negedge clk);
      if (!keep_valid) bus.sample_valid = 1'b0;
      checks++;
      if (bus.ram_wr !== 1'b1 || bus.ram_addr !== AW'((hist.size() - 1) % DEPTH) ||
          bus.ram_wdata !== data) begin
         errors++;
         $display("FAIL write_cycle: wr=%b addr=%0d data=%h want wr=1 addr=%0d data=%h",
                  bus.ram_wr, bus.ram_addr, bus.ram_wdata, (hist.size() - 1) % DEPTH, data);
      end
      @(negedge clk);
   endtask

   // mode 0: ready always 1; mode 1: random ready; mode 2: 5-cycle stall on tap 2
   task automatic drain(input int start, input int mode);
      int idx, cyc, stall;
      logic [DW-1:0] exp_d, held_d;
      logic [AW-1:0] held_a;
      idx = start; cyc = 0; stall = 0; held_d = '0; held_a = '0;
      while (idx < NT && cyc < 300) begin
         bus.tap_ready = 1'b1;
         if (mode == 1) bus.tap_ready = 1'($urandom_range(0, 1));
         if (mode == 2 && idx == 2 && bus.tap_valid && stall < 5) begin
            if (stall == 0) begin
               held_d = bus.tap_data;
               held_a = bus.ram_addr;
            end else begin
               checks++;
               if (bus.tap_data !== held_d || bus.tap_index !== AW'(2) || bus.ram_addr !== held_a) begin
                  errors++;
                  $display("FAIL stall_hold: data=%h idx=%0d addr=%0d want data=%h idx=2 addr=%0d",
                           bus.tap_data, bus.tap_index, bus.ram_addr, held_d, held_a);
               end
            end
            bus.tap_ready = 1'b0;
            stall++;
         end
         checks++;
         if (bus.ram_wr !== 1'b0 || bus.sample_ready !== 1'b0) begin
            errors++;
            $display("FAIL read_phase: wr=%b rdy=%b want 0 0", bus.ram_wr, bus.sample_ready);
         end
         if (bus.tap_valid && bus.tap_ready) begin
            checks++;
            if (bus.tap_index !== AW'(idx) || bus.tap_last !== (idx == NT - 1)) begin
               errors++;
               $display("FAIL tap_index: idx=%0d last=%b want idx=%0d last=%b",
                        bus.tap_index, bus.tap_last, idx, idx == NT - 1);
            end
            if (model_tap(idx, exp_d)) begin
               checks++;
               if (bus.tap_data !== exp_d) begin
                  errors++;
                  $display("FAIL tap_data: tap %0d got %h want %h", idx, bus.tap_data, exp_d);
               end
            end
            idx++;
         end
         @(negedge clk);
         cyc++;
      end
      bus.tap_ready = 1'b1;
      checks++;
      if (idx < NT) begin
         errors++;
         $display("FAIL drain_timeout: got %0d taps want %0d", idx, NT);
      end
      if (mode == 2) begin
         checks++;
         if (stall != 5) begin
            errors++;
            $display("FAIL stall_len: stalled %0d want 5", stall);
         end
      end
   endtask

   task automatic test_basic();
      accept(16'd1, 1'b0); drain(0, 0);
      accept(16'd2, 1'b0); drain(0, 0);
      accept(16'd3, 1'b0); drain(0, 0);
   endtask

   task automatic test_latency(input logic [DW-1:0] data);
      int wp;
      wp = hist.size() % DEPTH;
      accept(data, 1'b0);
      checks++;
      if (bus.tap_valid !== 1'b0 || bus.ram_addr !== AW'(wp)) begin
         errors++;
         $display("FAIL lat_n2: tv=%b addr=%0d want tv=0 addr=%0d", bus.tap_valid, bus.ram_addr, wp);
      end
      @(negedge clk);
      checks++;
      if (bus.tap_valid !== 1'b1 || bus.tap_data !== data || bus.tap_index !== '0 ||
          bus.ram_addr !== AW'((wp + DEPTH - 1) % DEPTH)) begin
         errors++;
         $display("FAIL lat_n3: tv=%b data=%h idx=%0d addr=%0d want tv=1 data=%h idx=0 addr=%0d",
                  bus.tap_valid, bus.tap_data, bus.tap_index, bus.ram_addr, data,
                  (wp + DEPTH - 1) % DEPTH);
      end
      drain(0, 0);
   endtask

   task automatic test_backpressure();
      accept(16'($urandom), 1'b0);
      drain(0, 2);
   endtask

   task automatic test_valid_held();
      logic [DW-1:0] a, b;
      a = 16'($urandom);
      b = a ^ 16'h5a5a;
      accept(a, 1'b1);
      bus.sample_data = b;
      drain(0, 0);
      checks++;
      if (bus.sample_ready !== 1'b1) begin
         errors++;
         $display("FAIL held_ready: sample_ready=%b want 1", bus.sample_ready);
      end
      @(posedge clk);
      hist.push_back(b);
      @(negedge clk);
      bus.sample_valid = 1'b0;
      checks++;
      if (bus.ram_wr !== 1'b1 || bus.ram_wdata !== b) begin
         errors++;
         $display("FAIL held_accept: wr=%b data=%h want wr=1 data=%h", bus.ram_wr, bus.ram_wdata, b);
      end
      @(negedge clk);
      drain(0, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         accept(16'($urandom), 1'b0);
         drain(0, 1);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < DEPTH && (hist.size() % DEPTH) != 0; i++) begin
         accept(16'($urandom), 1'b0);
         drain(0, 0);
      end
      test_latency(16'hbeef);
   endtask

   task automatic test_reset_mid();
      bit found;
      found = 1'b0;
      accept(16'($urandom), 1'b0);
      bus.tap_ready = 1'b1;
      for (int i = 0; i < 40 && !found; i++) begin
         if (bus.tap_valid && bus.tap_index == AW'(10)) found = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL find_tap10: tap 10 never seen");
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_mid_read");
      @(negedge clk);
      rst_n = 1'b1;
      hist.delete();
      check_post_reset();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      for (int i = 0; i < DEPTH; i++) ram[i] = 16'($urandom) | 16'h0001;
      bus.sample_valid = 1'b0;
      bus.sample_data  = '0;
      bus.tap_ready    = 1'b1;
      test_reset();
      test_basic();
      test_latency(16'h1234);
      test_backpressure();
      test_valid_held();
      test_random();
      test_wrap();
      test_reset_mid();
      test_basic();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
